// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR controller: FSM states, per-cap switch codes
// and the mapping from bit index to switched capacitor.
package sar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    COMPARE,
    SETTLE,
    DONE
  } state_e;

  // {h,l} codes for one DAC capacitor bottom plate
  localparam logic [1:0] SW_VREFP = 2'b10;
  localparam logic [1:0] SW_VREFN = 2'b01;
  localparam logic [1:0] SW_VCM   = 2'b00;

  // The decision on bit k (0 = MSB) switches cap k+1.
  function automatic int cap_idx(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/sar_logic_if.sv
// Signal bundle between the SAR controller and its comparator, cap DACs and requester.
interface sar_logic_if #(
  parameter int ADC_BITS = 8
);

  logic                  start;
  logic                  comp_valid;
  logic                  comp_out;
  logic                  sample;
  logic                  comp_en;
  logic [1:ADC_BITS-1]   dac_p_h;
  logic [1:ADC_BITS-1]   dac_p_l;
  logic [1:ADC_BITS-1]   dac_n_h;
  logic [1:ADC_BITS-1]   dac_n_l;
  logic [ADC_BITS-1:0]   dout;
  logic                  dout_valid;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    input  start, comp_valid, comp_out,
    output sample, comp_en, dac_p_h, dac_p_l, dac_n_h, dac_n_l,
           dout, dout_valid, busy, timeout_err
  );

  modport slave (
    output start, comp_valid, comp_out,
    input  sample, comp_en, dac_p_h, dac_p_l, dac_n_h, dac_n_l,
           dout, dout_valid, busy, timeout_err
  );

endinterface

// File: rtl/sar_logic.sv
// SAR controller for a monotonic-switching capacitor DAC pair: sample, then resolve one
// bit per comparator decision MSB first, switching one cap to vrefn per decided bit.
//
// state   | meaning
// IDLE    | waiting for start; DACs hold last pattern
// SAMPLE  | sample switch closed for SAMPLE_CYCLES
// COMPARE | comparator enabled, waiting for decision or timeout
// SETTLE  | comparator reset while the DAC settles
// DONE    | one-cycle result presentation
module sar_logic
  import sar_pkg::*;
#(
  parameter int ADC_BITS      = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int COMP_TIMEOUT  = 8
) (
  input logic          clk,
  input logic          rst_n,
  sar_logic_if.master  bus
);

  localparam int KW = $clog2(ADC_BITS);
  localparam int TMR_MAX =
      (SAMPLE_CYCLES > SETTLE_CYCLES)
        ? ((SAMPLE_CYCLES > COMP_TIMEOUT) ? SAMPLE_CYCLES : COMP_TIMEOUT)
        : ((SETTLE_CYCLES > COMP_TIMEOUT) ? SETTLE_CYCLES : COMP_TIMEOUT);
  localparam int TW = $clog2(TMR_MAX + 1);

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [ADC_BITS-1:0] res_q, res_d;
  logic [ADC_BITS-1:0] dout_q, dout_d;
  logic                terr_q, terr_d;
  logic [1:ADC_BITS-1] dac_p_h_q, dac_p_h_d, dac_p_l_q, dac_p_l_d;
  logic [1:ADC_BITS-1] dac_n_h_q, dac_n_h_d, dac_n_l_q, dac_n_l_d;
  logic                dec_fire, dec_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      tmr_q     <= '0;
      res_q     <= '0;
      dout_q    <= '0;
      terr_q    <= 1'b0;
      dac_p_h_q <= '1;
      dac_p_l_q <= '0;
      dac_n_h_q <= '1;
      dac_n_l_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      tmr_q     <= tmr_d;
      res_q     <= res_d;
      dout_q    <= dout_d;
      terr_q    <= terr_d;
      dac_p_h_q <= dac_p_h_d;
      dac_p_l_q <= dac_p_l_d;
      dac_n_h_q <= dac_n_h_d;
      dac_n_l_q <= dac_n_l_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    tmr_d     = tmr_q;
    res_d     = res_q;
    dout_d    = dout_q;
    terr_d    = terr_q;
    dac_p_h_d = dac_p_h_q;
    dac_p_l_d = dac_p_l_q;
    dac_n_h_d = dac_n_h_q;
    dac_n_l_d = dac_n_l_q;
    dec_fire  = 1'b0;
    dec_bit   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SAMPLE;
          tmr_d     = TW'(SAMPLE_CYCLES - 1);
          terr_d    = 1'b0;
          dac_p_h_d = '1;
          dac_p_l_d = '0;
          dac_n_h_d = '1;
          dac_n_l_d = '0;
        end
      end
      SAMPLE: begin
        if (tmr_q == '0) begin
          state_d = COMPARE;
          k_d     = '0;
          tmr_d   = TW'(COMP_TIMEOUT - 1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      COMPARE: begin
        if (bus.comp_valid) begin
          dec_fire = 1'b1;
          dec_bit  = bus.comp_out;
        end else if (tmr_q == '0) begin
          // No answer in time: assume the positive side is higher and flag it.
          dec_fire = 1'b1;
          dec_bit  = 1'b1;
          terr_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
        if (dec_fire) begin
          for (int i = 0; i < ADC_BITS; i++) begin
            if (i == ADC_BITS - 1 - int'(k_q)) res_d[i] = dec_bit;
          end
          if (k_q == KW'(ADC_BITS - 1)) begin
            state_d = DONE;
            dout_d  = res_d;
          end else begin
            for (int i = 1; i < ADC_BITS; i++) begin
              if (i == cap_idx(int'(k_q))) begin
                if (dec_bit) {dac_p_h_d[i], dac_p_l_d[i]} = SW_VREFN;
                else         {dac_n_h_d[i], dac_n_l_d[i]} = SW_VREFN;
              end
            end
            state_d = SETTLE;
            tmr_d   = TW'(SETTLE_CYCLES - 1);
          end
        end
      end
      SETTLE: begin
        if (tmr_q == '0) begin
          state_d = COMPARE;
          k_d     = k_q + KW'(1);
          tmr_d   = TW'(COMP_TIMEOUT - 1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.sample      = (state_q == SAMPLE);
  assign bus.comp_en     = (state_q == COMPARE);
  assign bus.dout_valid  = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.dout        = dout_q;
  assign bus.timeout_err = terr_q;
  assign bus.dac_p_h     = dac_p_h_q;
  assign bus.dac_p_l     = dac_p_l_q;
  assign bus.dac_n_h     = dac_n_h_q;
  assign bus.dac_n_l     = dac_n_l_q;

endmodule

// File: tb/tb_sar_logic.sv
// Directed bench for sar_logic: reset, fixed comparator patterns, timeout, abort,
// closed loop against an integer cap-DAC model, and back-to-back conversions.
module tb_sar_logic;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_logic_if #(.ADC_BITS(8)) bus ();
  sar_logic_if #(.ADC_BITS(8)) bus_to ();

  sar_logic #(.ADC_BITS(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1), .COMP_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  sar_logic #(.ADC_BITS(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1), .COMP_TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .bus(bus_to)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cmp_mode = 0;   // 0 silent, 1 pattern, 3 closed loop
  logic noise_en = 1'b0;
  logic pat [8];
  int   pat_idx = 0;
  int   en_cnt = 0;
  int   illegal_cnt = 0;
  int   valid_cnt = 0;
  int   vp, vn;

  // Node voltages in units of vref/1024; cap i moves its node by vref/2^(i+1).
  function automatic int dac_node(input int v0, input logic [1:7] sw_l);
    int v = v0;
    for (int i = 1; i < 8; i++) if (sw_l[i]) v -= (1024 >> (i + 1));
    return v;
  endfunction

  // Comparator model: answers on the second cycle of comp_en; optional spurious
  // comp_valid while disabled.
  always @(negedge clk) begin
    if ((bus.dac_p_h & bus.dac_p_l) != 7'h00 || (bus.dac_n_h & bus.dac_n_l) != 7'h00)
      illegal_cnt++;
    if (bus.dout_valid) valid_cnt++;
    if (!rst_n) begin
      en_cnt = 0;
      bus.comp_valid = 1'b0;
      bus.comp_out = 1'b0;
    end else if (bus.comp_en) begin
      en_cnt++;
      if (en_cnt == 2 && cmp_mode != 0) begin
        bus.comp_valid = 1'b1;
        if (cmp_mode == 1) begin
          bus.comp_out = pat[pat_idx % 8];
          pat_idx++;
        end else begin
          vp = dac_node(640, bus.dac_p_l);
          vn = dac_node(384, bus.dac_n_l);
          bus.comp_out = (vp > vn);
        end
      end else begin
        bus.comp_valid = 1'b0;
      end
    end else begin
      en_cnt = 0;
      bus.comp_valid = noise_en;
      bus.comp_out = 1'b0;
    end
  end

  task automatic run_conv(input int pulse_at, output int ncyc, output logic [7:0] got,
                          output logic [7:0] early, output int nvalid);
    int v0;
    v0 = valid_cnt;
    pat_idx = 0;
    got = 8'h00;
    early = 8'h00;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ncyc = 0;
    while (bus.busy && ncyc < 300) begin
      ncyc++;
      if (bus.dout_valid) got = bus.dout;
      if (ncyc == 5) early = bus.dout;
      bus.start = (ncyc == pulse_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
    @(negedge clk);
    nvalid = valid_cnt - v0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.start = i[0];
      bus_to.start = i[0];
      @(negedge clk);
      n_cmp++;
      if ({bus.sample, bus.comp_en, bus.dout_valid, bus.busy, bus.timeout_err} !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_ctrl: got %b want 00000", {bus.sample, bus.comp_en, bus.dout_valid, bus.busy, bus.timeout_err});
      end
      n_cmp++;
      if ({bus.dac_p_h, bus.dac_p_l, bus.dac_n_h, bus.dac_n_l} !== {7'h7F, 7'h00, 7'h7F, 7'h00}) begin
        n_bad++;
        $display("FAIL reset_dac: got %h %h %h %h want 7f 00 7f 00", bus.dac_p_h, bus.dac_p_l, bus.dac_n_h, bus.dac_n_l);
      end
      n_cmp++;
      if (bus.dout !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_dout: got %h want 00", bus.dout);
      end
    end
    bus.start = 1'b0;
    bus_to.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    int ncyc, nvalid;
    logic [7:0] got, early;
    cmp_mode = 1;
    noise_en = 1'b1;
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_conv(-1, ncyc, got, early, nvalid);
    n_cmp++;
    if (got !== 8'hFF) begin n_bad++; $display("FAIL ones_dout: got %h want ff", got); end
    n_cmp++;
    if (ncyc != 26) begin n_bad++; $display("FAIL ones_busy_cycles: got %0d want 26", ncyc); end
    n_cmp++;
    if (nvalid != 1) begin n_bad++; $display("FAIL ones_valid_pulses: got %0d want 1", nvalid); end
    n_cmp++;
    if ({bus.dac_p_h, bus.dac_p_l} !== {7'h00, 7'h7F}) begin
      n_bad++; $display("FAIL ones_dac_p: got %h %h want 00 7f", bus.dac_p_h, bus.dac_p_l);
    end
    n_cmp++;
    if ({bus.dac_n_h, bus.dac_n_l} !== {7'h7F, 7'h00}) begin
      n_bad++; $display("FAIL ones_dac_n: got %h %h want 7f 00", bus.dac_n_h, bus.dac_n_l);
    end
    n_cmp++;
    if (bus.timeout_err !== 1'b0) begin n_bad++; $display("FAIL ones_timeout_err: got %b want 0", bus.timeout_err); end
    n_cmp++;
    if (bus.dout !== 8'hFF) begin n_bad++; $display("FAIL ones_dout_hold: got %h want ff", bus.dout); end
  endtask

  task automatic test_alternating();
    int ncyc, nvalid;
    logic [7:0] got, early;
    cmp_mode = 1;
    noise_en = 1'b1;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    run_conv(-1, ncyc, got, early, nvalid);
    n_cmp++;
    if (got !== 8'hAA) begin n_bad++; $display("FAIL alt_dout: got %h want aa", got); end
    n_cmp++;
    if (early !== 8'hFF) begin n_bad++; $display("FAIL alt_dout_held_midconv: got %h want ff", early); end
    n_cmp++;
    if ({bus.dac_p_h, bus.dac_p_l} !== {7'h2A, 7'h55}) begin
      n_bad++; $display("FAIL alt_dac_p: got %h %h want 2a 55", bus.dac_p_h, bus.dac_p_l);
    end
    n_cmp++;
    if ({bus.dac_n_h, bus.dac_n_l} !== {7'h55, 7'h2A}) begin
      n_bad++; $display("FAIL alt_dac_n: got %h %h want 55 2a", bus.dac_n_h, bus.dac_n_l);
    end
    n_cmp++;
    if (illegal_cnt != 0) begin n_bad++; $display("FAIL alt_illegal_11: got %0d cycles want 0", illegal_cnt); end
  endtask

  task automatic test_timeout();
    int n, tot_en, first_run;
    logic seen_drop;
    logic [7:0] got;
    bus_to.comp_valid = 1'b0;
    bus_to.comp_out = 1'b0;
    @(negedge clk);
    bus_to.start = 1'b1;
    @(negedge clk);
    bus_to.start = 1'b0;
    n = 0; tot_en = 0; first_run = 0; seen_drop = 1'b0; got = 8'h00;
    while (bus_to.busy && n < 300) begin
      n++;
      if (bus_to.comp_en) tot_en++;
      if (bus_to.comp_en && !seen_drop) first_run++;
      if (!bus_to.comp_en && first_run > 0) seen_drop = 1'b1;
      if (bus_to.dout_valid) got = bus_to.dout;
      @(negedge clk);
    end
    n_cmp++;
    if (got !== 8'hFF) begin n_bad++; $display("FAIL to_dout: got %h want ff", got); end
    n_cmp++;
    if (n != 42) begin n_bad++; $display("FAIL to_busy_cycles: got %0d want 42", n); end
    n_cmp++;
    if (first_run != 4) begin n_bad++; $display("FAIL to_compare_len: got %0d want 4", first_run); end
    n_cmp++;
    if (tot_en != 32) begin n_bad++; $display("FAIL to_total_compare: got %0d want 32", tot_en); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus_to.timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_err_sticky: got %b want 1", bus_to.timeout_err); end
    bus_to.start = 1'b1;
    @(negedge clk);
    bus_to.start = 1'b0;
    n_cmp++;
    if (bus_to.timeout_err !== 1'b0 || bus_to.sample !== 1'b1) begin
      n_bad++; $display("FAIL to_err_clear_on_start: got err=%b sample=%b want err=0 sample=1", bus_to.timeout_err, bus_to.sample);
    end
    n = 0;
    while (bus_to.busy && n < 300) begin n++; @(negedge clk); end
  endtask

  task automatic test_abort();
    int ncyc, nvalid, v0, n, settles;
    logic prev_settle, in_settle;
    logic [7:0] got, early;
    cmp_mode = 1;
    noise_en = 1'b0;
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    pat_idx = 0;
    v0 = valid_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0; settles = 0; prev_settle = 1'b0;
    while (settles < 4 && n < 200) begin
      in_settle = bus.busy && !bus.sample && !bus.comp_en && !bus.dout_valid;
      if (in_settle && !prev_settle) settles++;
      prev_settle = in_settle;
      if (settles < 4) begin n++; @(negedge clk); end
    end
    n_cmp++;
    if (settles != 4) begin n_bad++; $display("FAIL abort_reach_settle: got %0d settles want 4", settles); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.sample, bus.comp_en, bus.dout_valid, bus.busy, bus.timeout_err} !== 5'b0) begin
      n_bad++; $display("FAIL abort_ctrl: got %b want 00000", {bus.sample, bus.comp_en, bus.dout_valid, bus.busy, bus.timeout_err});
    end
    n_cmp++;
    if ({bus.dac_p_h, bus.dac_p_l, bus.dac_n_h, bus.dac_n_l} !== {7'h7F, 7'h00, 7'h7F, 7'h00}) begin
      n_bad++; $display("FAIL abort_dac: got %h %h %h %h want 7f 00 7f 00", bus.dac_p_h, bus.dac_p_l, bus.dac_n_h, bus.dac_n_l);
    end
    n_cmp++;
    if (bus.dout !== 8'h00) begin n_bad++; $display("FAIL abort_dout: got %h want 00", bus.dout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (valid_cnt != v0) begin n_bad++; $display("FAIL abort_no_valid: got %0d pulses want 0", valid_cnt - v0); end
    run_conv(-1, ncyc, got, early, nvalid);
    n_cmp++;
    if (got !== 8'hFF || ncyc != 26 || nvalid != 1) begin
      n_bad++; $display("FAIL abort_reconv: got dout=%h cyc=%0d valid=%0d want ff 26 1", got, ncyc, nvalid);
    end
  endtask

  task automatic test_closed_loop();
    int ncyc, nvalid;
    logic [7:0] got, early;
    cmp_mode = 3;
    noise_en = 1'b0;
    run_conv(10, ncyc, got, early, nvalid);
    n_cmp++;
    if (got !== 8'hBF && got !== 8'hC0) begin n_bad++; $display("FAIL loop_dout: got %h want bf or c0", got); end
    n_cmp++;
    if (ncyc != 26 || nvalid != 1) begin
      n_bad++; $display("FAIL loop_start_ignored: got cyc=%0d valid=%0d want 26 1", ncyc, nvalid);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL loop_idle_after: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int n, gap, v0;
    cmp_mode = 1;
    noise_en = 1'b0;
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    pat_idx = 0;
    v0 = valid_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    n = 0;
    while (!bus.dout_valid && n < 100) begin n++; @(negedge clk); end
    @(negedge clk);
    gap = 0;
    while (!bus.busy && gap < 10) begin gap++; @(negedge clk); end
    bus.start = 1'b0;
    n_cmp++;
    if (gap != 1) begin n_bad++; $display("FAIL b2b_idle_gap: got %0d want 1", gap); end
    n = 0;
    while (bus.busy && n < 100) begin n++; @(negedge clk); end
    @(negedge clk);
    n_cmp++;
    if (valid_cnt - v0 != 2 || bus.dout !== 8'hFF) begin
      n_bad++; $display("FAIL b2b_two_results: got valid=%0d dout=%h want 2 ff", valid_cnt - v0, bus.dout);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus_to.start = 1'b0;
    bus_to.comp_valid = 1'b0;
    bus_to.comp_out = 1'b0;
    test_reset();
    test_all_ones();
    test_alternating();
    test_timeout();
    test_abort();
    test_closed_loop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
